// File: rtl/fx_vibrato_scheduler.sv
// Shared vibrato LFO sequencer: walks all voices on each note tick and offers pitch offsets over valid/ready.
// Optional build macro FX_VIB_SKIP_UNCHANGED_EN suppresses offers whose mul/dir match the last transfer.
module fx_vibrato_scheduler #(
    parameter int VOICE_W  = 2,
    parameter int TICK_DIV = 50000
) (
    input  logic                          clk50mhz,
    input  logic                          rst,
    input  logic [(1<<VOICE_W)-1:0]       en,
    input  logic [2*(1<<VOICE_W)-1:0]     speed,
    input  logic [2*(1<<VOICE_W)-1:0]     depth,
    output logic                          upd_valid,
    input  logic                          upd_ready,
    output logic [VOICE_W-1:0]            upd_voice,
    output logic [2:0]                    upd_mul,
    output logic                          upd_dir,
    output logic                          busy,
    output logic                          tick_miss
);

    localparam int N     = 1 << VOICE_W;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CALC  = 2'd2,
        OFFER = 2'd3
    } state_e;

    // Triangle fold of the 4-bit phase, then scaled by depth with rounding.
    function automatic logic [2:0] mul_f(input logic [3:0] phase, input logic [1:0] dep);
        logic [2:0] tri_v;
        logic [2:0] m_v;
        tri_v = phase[3] ? ~phase[2:0] : phase[2:0];
        case (dep)
            2'd3:    m_v = tri_v;
            2'd2:    m_v = 3'(({1'b0, tri_v} + 4'd1) >> 1);
            2'd1:    m_v = 3'(({1'b0, tri_v} + 4'd2) >> 2);
            default: m_v = tri_v >> 2;
        endcase
        return m_v;
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     tick_cnt_q;
    logic [VOICE_W-1:0]   idx_q, idx_d;
    logic                 upd_valid_q, upd_valid_d;
    logic [VOICE_W-1:0]   upd_voice_q, upd_voice_d;
    logic [2:0]           upd_mul_q, upd_mul_d;
    logic                 upd_dir_q, upd_dir_d;
    logic                 tick_miss_q, tick_miss_d;
    logic                 w_en_q;
    logic [1:0]           w_speed_q, w_depth_q;
    logic [1:0]           pre_q   [N];
    logic [3:0]           phase_q [N];
    logic                 dir_q   [N];
    logic                 tick_s, load_s, calc_s, last_idx_s, skip_s;
    logic [1:0]           new_pre_s;
    logic [3:0]           new_phase_s;
    logic                 new_dir_s;
    logic [2:0]           new_mul_s;

    assign tick_s     = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    assign last_idx_s = &idx_q;

    // Note-tick prescaler.
    always_ff @(posedge clk50mhz) begin
        if (rst || tick_s) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
    end

    // Voice state update computed from the working registers latched in LOAD.
    always_comb begin
        new_pre_s   = 2'd0;
        new_phase_s = 4'd0;
        new_dir_s   = 1'b0;
        if (!w_en_q) begin
            new_pre_s   = 2'd0;
            new_phase_s = 4'd0;
            new_dir_s   = 1'b0;
        end else if (pre_q[idx_q] == w_speed_q) begin
            new_pre_s   = 2'd0;
            new_phase_s = phase_q[idx_q] + 4'd1;
            new_dir_s   = (phase_q[idx_q] == 4'hF) ? ~dir_q[idx_q] : dir_q[idx_q];
        end else begin
            new_pre_s   = pre_q[idx_q] + 2'd1;
            new_phase_s = phase_q[idx_q];
            new_dir_s   = dir_q[idx_q];
        end
        new_mul_s = mul_f(new_phase_s, w_depth_q);
    end

`ifdef FX_VIB_SKIP_UNCHANGED_EN
    logic [2:0] last_mul_q [N];
    logic       last_dir_q [N];

    assign skip_s = (new_mul_s == last_mul_q[idx_q]) && (new_dir_s == last_dir_q[idx_q]);

    // Remember what the pitch-bend stage last accepted per voice.
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                last_mul_q[i] <= 3'd0;
                last_dir_q[i] <= 1'b0;
            end
        end else if ((state_q == OFFER) && upd_ready) begin
            last_mul_q[idx_q] <= upd_mul_q;
            last_dir_q[idx_q] <= upd_dir_q;
        end
    end
`else
    assign skip_s = 1'b0;
`endif

    // Sequencer next-state and registered-output next values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        upd_valid_d = upd_valid_q;
        upd_voice_d = upd_voice_q;
        upd_mul_d   = upd_mul_q;
        upd_dir_d   = upd_dir_q;
        tick_miss_d = tick_miss_q | (tick_s & (state_q != IDLE));
        load_s      = 1'b0;
        calc_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                load_s  = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                calc_s = 1'b1;
                if (skip_s) begin
                    if (last_idx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                        idx_d   = idx_q + VOICE_W'(1);
                    end
                end else begin
                    state_d     = OFFER;
                    upd_valid_d = 1'b1;
                    upd_voice_d = idx_q;
                    upd_mul_d   = new_mul_s;
                    upd_dir_d   = new_dir_s;
                end
            end
            OFFER: begin
                if (upd_ready) begin
                    upd_valid_d = 1'b0;
                    if (last_idx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                        idx_d   = idx_q + VOICE_W'(1);
                    end
                end else begin
                    state_d = OFFER;
                end
            end
            default: begin
                state_d     = IDLE;
                upd_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_voice_q <= '0;
            upd_mul_q   <= 3'd0;
            upd_dir_q   <= 1'b0;
            tick_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            upd_valid_q <= upd_valid_d;
            upd_voice_q <= upd_voice_d;
            upd_mul_q   <= upd_mul_d;
            upd_dir_q   <= upd_dir_d;
            tick_miss_q <= tick_miss_d;
        end
    end

    // Inputs are sampled for the current voice only in LOAD.
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            w_en_q    <= 1'b0;
            w_speed_q <= 2'd0;
            w_depth_q <= 2'd0;
        end else if (load_s) begin
            w_en_q    <= en[idx_q];
            w_speed_q <= speed[{idx_q, 1'b0} +: 2];
            w_depth_q <= depth[{idx_q, 1'b0} +: 2];
        end
    end

    // Per-voice LFO state, written back in CALC.
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                pre_q[i]   <= 2'd0;
                phase_q[i] <= 4'd0;
                dir_q[i]   <= 1'b0;
            end
        end else if (calc_s) begin
            pre_q[idx_q]   <= new_pre_s;
            phase_q[idx_q] <= new_phase_s;
            dir_q[idx_q]   <= new_dir_s;
        end
    end

    assign upd_valid = upd_valid_q;
    assign upd_voice = upd_voice_q;
    assign upd_mul   = upd_mul_q;
    assign upd_dir   = upd_dir_q;
    assign busy      = (state_q != IDLE);
    assign tick_miss = tick_miss_q;

endmodule

// File: tb/tb_fx_vibrato_scheduler.sv
// Scoreboard bench for fx_vibrato_scheduler (VOICE_W=2, TICK_DIV=8); a behavioural LFO model predicts each pass.
module tb_fx_vibrato_scheduler;

    localparam int VW = 2;
    localparam int NV = 4;
    localparam int TD = 8;

    logic          clk50mhz = 1'b0;
    logic          rst = 1'b1;
    logic [NV-1:0] en = '0;
    logic [2*NV-1:0] speed = '0;
    logic [2*NV-1:0] depth = '0;
    logic          upd_ready = 1'b1;
    logic          upd_valid;
    logic [VW-1:0] upd_voice;
    logic [2:0]    upd_mul;
    logic          upd_dir;
    logic          busy;
    logic          tick_miss;

    fx_vibrato_scheduler #(.VOICE_W(VW), .TICK_DIV(TD)) dut (
        .clk50mhz (clk50mhz),
        .rst      (rst),
        .en       (en),
        .speed    (speed),
        .depth    (depth),
        .upd_valid(upd_valid),
        .upd_ready(upd_ready),
        .upd_voice(upd_voice),
        .upd_mul  (upd_mul),
        .upd_dir  (upd_dir),
        .busy     (busy),
        .tick_miss(tick_miss)
    );

    always #10 clk50mhz = ~clk50mhz;

    typedef struct {
        int voice;
        int mul;
        int dir;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   m_pre [NV];
    int   m_ph  [NV];
    int   m_dir [NV];
    int   m_lmul[NV];
    int   m_ldir[NV];

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_pre[i] = 0; m_ph[i] = 0; m_dir[i] = 0; m_lmul[i] = 0; m_ldir[i] = 0;
        end
        sb_q.delete();
    endtask

    task automatic model_voice(input int v, output int mul, output int dir);
        int sp, dp, tri_v;
        sp = int'(speed[2*v +: 2]);
        dp = int'(depth[2*v +: 2]);
        if (en[v] == 1'b0) begin
            m_pre[v] = 0; m_ph[v] = 0; m_dir[v] = 0;
        end else if (m_pre[v] == sp) begin
            m_pre[v] = 0;
            m_ph[v]  = (m_ph[v] + 1) % 16;
            if (m_ph[v] == 0) m_dir[v] = 1 - m_dir[v];
        end else begin
            m_pre[v] = m_pre[v] + 1;
        end
        tri_v = (m_ph[v] < 8) ? m_ph[v] : 15 - m_ph[v];
        case (dp)
            3:       mul = tri_v;
            2:       mul = (tri_v + 1) / 2;
            1:       mul = (tri_v + 2) / 4;
            default: mul = tri_v / 4;
        endcase
        dir = m_dir[v];
    endtask

    task automatic push_pass(output int n);
        int mul, dir;
        bit skip;
        n = 0;
        for (int v = 0; v < NV; v++) begin
            model_voice(v, mul, dir);
            skip = 1'b0;
`ifdef FX_VIB_SKIP_UNCHANGED_EN
            skip = (mul == m_lmul[v]) && (dir == m_ldir[v]);
`endif
            if (!skip) begin
                sb_q.push_back('{v, mul, dir});
                m_lmul[v] = mul;
                m_ldir[v] = dir;
                n++;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk50mhz);
        rst = 1'b1;
        @(negedge clk50mhz);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int t;
        t = 0;
        while (busy !== lvl && t < 100) begin
            @(negedge clk50mhz);
            t++;
        end
        total_cnt++;
        if (busy !== lvl) $display("FAIL %s busy wait: got %b want %b", tag, busy, lvl);
        else pass_cnt++;
    endtask

    // One full voice pass; hold>0 keeps upd_ready low for that many cycles at the first offer.
    task automatic do_pass(input int hold, input string tag);
        int   n, t;
        exp_t e;
        push_pass(n);
        if (hold > 0) upd_ready = 1'b0;
        wait_busy(1'b1, tag);
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (upd_valid !== 1'b1 && t < 100) begin
                @(negedge clk50mhz);
                t++;
            end
            e = sb_q.pop_front();
            total_cnt++;
            if (upd_valid !== 1'b1) begin
                $display("FAIL %s offer timeout: voice %0d not offered", tag, e.voice);
            end else begin
                pass_cnt++;
                if (hold > 0 && k == 0) begin
                    for (int c = 0; c < hold; c++) begin
                        total_cnt++;
                        if ({upd_valid, upd_voice, upd_mul, upd_dir} !==
                            {1'b1, 2'(e.voice), 3'(e.mul), 1'(e.dir)})
                            $display("FAIL %s stall c%0d: got v=%b voice=%0d mul=%0d dir=%0d want v=1 voice=%0d mul=%0d dir=%0d",
                                     tag, c, upd_valid, upd_voice, upd_mul, upd_dir, e.voice, e.mul, e.dir);
                        else pass_cnt++;
                        @(negedge clk50mhz);
                    end
                    upd_ready = 1'b1;
                end
                total_cnt++;
                if ({upd_voice, upd_mul, upd_dir} !== {2'(e.voice), 3'(e.mul), 1'(e.dir)})
                    $display("FAIL %s offer: got voice=%0d mul=%0d dir=%0d want voice=%0d mul=%0d dir=%0d",
                             tag, upd_voice, upd_mul, upd_dir, e.voice, e.mul, e.dir);
                else pass_cnt++;
                @(negedge clk50mhz);
            end
        end
        wait_busy(1'b0, tag);
    endtask

    task automatic test_reset();
        en = '0; speed = '0; depth = '0; upd_ready = 1'b1;
        apply_reset();
        total_cnt++;
        if ({upd_valid, busy, tick_miss, upd_voice, upd_mul, upd_dir} !== 9'd0)
            $display("FAIL reset outputs: got valid=%b busy=%b miss=%b voice=%0d mul=%0d dir=%b want all 0",
                     upd_valid, busy, tick_miss, upd_voice, upd_mul, upd_dir);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        apply_reset();
        repeat (7) @(negedge clk50mhz);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL latency idle: busy got %b want 0", busy); else pass_cnt++;
        @(negedge clk50mhz);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL latency load: busy got %b want 1", busy); else pass_cnt++;
        @(negedge clk50mhz);
        total_cnt++;
        if (upd_valid !== 1'b0) $display("FAIL latency calc: valid got %b want 0", upd_valid); else pass_cnt++;
        @(negedge clk50mhz);
        total_cnt++;
        if (upd_valid !== 1'b1) $display("FAIL latency offer: valid got %b want 1", upd_valid); else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_depth3_sweep();
        en = 4'b0001; speed = 8'h00; depth = 8'h03;
        apply_reset();
        for (int i = 0; i < 16; i++) do_pass(0, "depth3");
    endtask

    task automatic test_depth0();
        en = 4'b0001; speed = 8'h00; depth = 8'h00;
        apply_reset();
        for (int i = 0; i < 16; i++) do_pass(0, "depth0");
    endtask

    task automatic test_speed2();
        en = 4'b0001; speed = 8'h02; depth = 8'h03;
        apply_reset();
        for (int i = 0; i < 9; i++) do_pass(0, "speed2");
    endtask

    task automatic test_stall();
        en = 4'b0001; speed = 8'h00; depth = 8'h03;
        apply_reset();
        do_pass(20, "stall");
        total_cnt++;
        if (tick_miss !== 1'b1) $display("FAIL stall tick_miss: got %b want 1", tick_miss); else pass_cnt++;
        do_pass(0, "after_stall");
    endtask

    task automatic test_en_drop();
        en = 4'b0010; speed = 8'h00; depth = 8'h0C;
        apply_reset();
        for (int i = 0; i < 5; i++) do_pass(0, "en1_on");
        en = 4'b0000;
        do_pass(0, "en1_off");
        en = 4'b0010;
        do_pass(0, "en1_again");
    endtask

    task automatic test_rst_during_offer();
        int t;
        en = 4'b0101; speed = 8'h00; depth = 8'h33;
        apply_reset();
        do_pass(0, "pre_rst");
        do_pass(0, "pre_rst");
        upd_ready = 1'b0;
        t = 0;
        while (upd_valid !== 1'b1 && t < 100) begin
            @(negedge clk50mhz);
            t++;
        end
        rst = 1'b1;
        @(negedge clk50mhz);
        total_cnt++;
        if ({upd_valid, busy, tick_miss} !== 3'b000)
            $display("FAIL rst_offer: got valid=%b busy=%b miss=%b want 000", upd_valid, busy, tick_miss);
        else pass_cnt++;
        rst = 1'b0;
        model_reset();
        upd_ready = 1'b1;
        do_pass(0, "post_rst");
    endtask

`ifdef FX_VIB_SKIP_UNCHANGED_EN
    task automatic test_skip();
        en = 4'b0001; speed = 8'h03; depth = 8'h03;
        apply_reset();
        for (int i = 0; i < 8; i++) do_pass(0, "skip");
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_depth3_sweep();
        test_depth0();
        test_speed2();
        test_stall();
        test_en_drop();
        test_rst_during_offer();
`ifdef FX_VIB_SKIP_UNCHANGED_EN
        test_skip();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
